// File: rtl/regblock_seq.sv
// Command sequencer and sole master of the 8 x 8-bit register block ports.
// Optional write protection enabled by defining REGSEQ_PROTECT_EN (uses PROTECT_MASK).
module regblock_seq #(
  parameter logic [7:0] PROTECT_MASK = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_dst,
  input  logic [2:0] cmd_src,
  input  logic [7:0] cmd_imm,
  output logic       done,
  output logic       err,
  output logic       rf_we,
  output logic [2:0] rf_iaddr,
  output logic [7:0] rf_idata,
  output logic       rf_oe,
  output logic [2:0] rf_oaddr,
  input  logic [7:0] rf_odata
);

`ifdef REGSEQ_PROTECT_EN
  localparam logic PROTECT_ON = 1'b1;
`else
  localparam logic PROTECT_ON = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_DONE = 4'd1,
    S_LW   = 4'd2,
    S_MR   = 4'd3,
    S_MW   = 4'd4,
    S_SRA  = 4'd5,
    S_SRB  = 4'd6,
    S_SWA  = 4'd7,
    S_SWB  = 4'd8
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [2:0]  dst_r;
  logic [2:0]  src_r;
  logic [7:0]  imm_r;
  logic [7:0]  tmp_a_r;
  logic [7:0]  tmp_b_r;
  logic        sup_r;

  logic        accept_s;
  logic        ready_s;
  logic        done_s;
  logic        we_s;
  logic        oe_s;
  logic [2:0]  iaddr_s;
  logic [2:0]  oaddr_s;
  logic [7:0]  idata_s;
  logic        blk_s;

  function automatic logic wr_blocked(input logic [2:0] addr);
    return PROTECT_ON & PROTECT_MASK[addr];
  endfunction

  assign accept_s = (state_r == S_IDLE) & cmd_valid;
  assign blk_s    = we_s & wr_blocked(iaddr_s);

  // State, latched command fields and read-back temporaries
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      dst_r   <= 3'd0;
      src_r   <= 3'd0;
      imm_r   <= 8'h00;
      tmp_a_r <= 8'h00;
      tmp_b_r <= 8'h00;
      sup_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        dst_r <= cmd_dst;
        src_r <= cmd_src;
        imm_r <= cmd_imm;
      end
      if ((state_r == S_MR) || (state_r == S_SRA)) begin
        tmp_a_r <= rf_odata;
      end
      if (state_r == S_SRB) begin
        tmp_b_r <= rf_odata;
      end
      // remembers a suppressed SWA write until the command's done cycle
      sup_r <= done_s ? 1'b0 : (sup_r | blk_s);
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_next_s = state_r;
    ready_s      = 1'b0;
    done_s       = 1'b0;
    we_s         = 1'b0;
    oe_s         = 1'b0;
    iaddr_s      = 3'd0;
    oaddr_s      = 3'd0;
    idata_s      = 8'h00;
    case (state_r)
      S_IDLE: begin
        ready_s = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            2'd0:    state_next_s = S_DONE;
            2'd1:    state_next_s = S_LW;
            2'd2:    state_next_s = S_MR;
            2'd3:    state_next_s = S_SRA;
            default: state_next_s = S_IDLE;
          endcase
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_DONE: begin
        done_s       = 1'b1;
        state_next_s = S_IDLE;
      end
      S_LW: begin
        we_s         = 1'b1;
        iaddr_s      = dst_r;
        idata_s      = imm_r;
        done_s       = 1'b1;
        state_next_s = S_IDLE;
      end
      S_MR: begin
        oe_s         = 1'b1;
        oaddr_s      = src_r;
        state_next_s = S_MW;
      end
      S_MW: begin
        we_s         = 1'b1;
        iaddr_s      = dst_r;
        idata_s      = tmp_a_r;
        done_s       = 1'b1;
        state_next_s = S_IDLE;
      end
      S_SRA: begin
        oe_s         = 1'b1;
        oaddr_s      = src_r;
        state_next_s = S_SRB;
      end
      S_SRB: begin
        oe_s         = 1'b1;
        oaddr_s      = dst_r;
        state_next_s = S_SWA;
      end
      S_SWA: begin
        we_s         = 1'b1;
        iaddr_s      = dst_r;
        idata_s      = tmp_a_r;
        state_next_s = S_SWB;
      end
      S_SWB: begin
        we_s         = 1'b1;
        iaddr_s      = src_r;
        idata_s      = tmp_b_r;
        done_s       = 1'b1;
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // reset forces every output quiet in the same cycle, so an aborted command issues no write
  assign cmd_ready = ready_s & ~rst;
  assign done      = done_s & ~rst;
  assign err       = done_s & (blk_s | sup_r) & ~rst;
  assign rf_we     = we_s & ~blk_s & ~rst;
  assign rf_oe     = oe_s & ~rst;
  assign rf_iaddr  = rst ? 3'd0 : iaddr_s;
  assign rf_oaddr  = rst ? 3'd0 : oaddr_s;
  assign rf_idata  = rst ? 8'h00 : idata_s;

endmodule

// File: tb/tb_regblock_seq.sv
// Scoreboard bench for regblock_seq with a behavioural register-file model.
module tb_regblock_seq;

`ifdef REGSEQ_PROTECT_EN
  localparam logic [7:0] EFF_MASK = 8'h01;
`else
  localparam logic [7:0] EFF_MASK = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [2:0] cmd_dst = 3'd0;
  logic [2:0] cmd_src = 3'd0;
  logic [7:0] cmd_imm = 8'h00;
  logic       done, err, rf_we, rf_oe;
  logic [2:0] rf_iaddr, rf_oaddr;
  logic [7:0] rf_idata, rf_odata;

  regblock_seq #(.PROTECT_MASK(8'h01)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
    .done(done), .err(err), .rf_we(rf_we), .rf_iaddr(rf_iaddr), .rf_idata(rf_idata),
    .rf_oe(rf_oe), .rf_oaddr(rf_oaddr), .rf_odata(rf_odata)
  );

  always #5 clk = ~clk;

  // register block the sequencer drives
  logic [7:0] mem [8] = '{default: 8'h00};
  always @(posedge clk) if (rf_we) mem[rf_iaddr] <= rf_idata;
  assign rf_odata = rf_oe ? mem[rf_oaddr] : 8'h00;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          exp_cyc;
    logic        err;
    logic        we;
    logic [2:0]  waddr;
    logic [7:0]  wdata;
    logic [63:0] img;
  } item_t;

  item_t       sb_q[$];
  logic [7:0]  ref_mem [8] = '{default: 8'h00};
  int          tests = 0;
  int          fails = 0;
  int          overlap = 0;
  bit          pend = 1'b0;
  logic [63:0] pend_img;

  function automatic logic [63:0] pack_mem(input logic [7:0] m [8]);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = m[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference semantics: what each command does to the register file
  task automatic model(input logic [1:0] op, input logic [2:0] d, input logic [2:0] s,
                       input logic [7:0] im, input int acc, output int busy);
    item_t it;
    logic [7:0] a, b;
    busy = (op == 2'd3) ? 4 : (op == 2'd2) ? 2 : 1;
    it.exp_cyc = acc + busy;
    it.err = 1'b0; it.we = 1'b0; it.waddr = 3'd0; it.wdata = 8'h00;
    if (op == 2'd1 || op == 2'd2) begin
      a = (op == 2'd1) ? im : ref_mem[s];
      if (EFF_MASK[d]) it.err = 1'b1; else ref_mem[d] = a;
      it.we = !EFF_MASK[d]; it.waddr = d; it.wdata = a;
    end else if (op == 2'd3) begin
      a = ref_mem[s];
      b = ref_mem[d];
      if (EFF_MASK[d]) it.err = 1'b1; else ref_mem[d] = a;
      if (EFF_MASK[s]) it.err = 1'b1; else ref_mem[s] = b;
      it.we = !EFF_MASK[s]; it.waddr = s; it.wdata = b;
    end
    it.img = pack_mem(ref_mem);
    sb_q.push_back(it);
  endtask

  // monitor: pops the scoreboard whenever the DUT reports done
  always @(negedge clk) begin
    item_t it;
    if (rf_we && rf_oe) overlap++;
    if (pend) begin
      pend = 1'b0;
      check("rf_image", pack_mem(mem), pend_img);
    end
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got done=1 expected no command in flight (cycle %0d)", cyc);
      end else begin
        it = sb_q.pop_front();
        check("done_cycle", cyc, it.exp_cyc);
        check("err", err, it.err);
        check("final_we", rf_we, it.we);
        if (it.we) begin
          check("final_waddr", rf_iaddr, it.waddr);
          check("final_wdata", rf_idata, it.wdata);
        end
        pend = 1'b1;
        pend_img = it.img;
      end
    end
  end

  // called at a negedge; returns at the first idle negedge after the command
  task automatic issue(input logic [1:0] op, input logic [2:0] d, input logic [2:0] s,
                       input logic [7:0] im, input bit hold, output int acc);
    int w, b;
    cmd_op = op; cmd_dst = d; cmd_src = s; cmd_imm = im; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    acc = cyc;
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got cmd_ready=0 expected 1 within 50 cycles");
      cmd_valid = 1'b0;
      return;
    end
    model(op, d, s, im, acc, b);
    @(posedge clk);
    for (int i = 0; i < b; i++) begin
      @(negedge clk);
      cmd_op = 2'($urandom); cmd_dst = 3'($urandom); cmd_src = 3'($urandom);
      cmd_imm = 8'($urandom);
      cmd_valid = hold ? 1'b1 : 1'($urandom);
      check("ready_busy", cmd_ready, 1'b0);
    end
    @(negedge clk);
    cmd_valid = hold;
  endtask

  initial begin
    int acc, p0, p1, p2, p3, w;
    logic [1:0] op;
    logic [2:0] d, s;

    repeat (2) @(negedge clk);
    check("reset_outputs", {cmd_ready, done, err, rf_we, rf_oe, rf_iaddr, rf_oaddr, rf_idata}, 19'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1'b1);

    issue(2'd1, 3'd3, 3'd0, 8'hA5, 1'b0, acc);
    issue(2'd1, 3'd1, 3'd0, 8'h3C, 1'b0, acc);
    issue(2'd2, 3'd6, 3'd1, 8'h00, 1'b0, acc);
    issue(2'd1, 3'd2, 3'd0, 8'h11, 1'b0, acc);
    issue(2'd1, 3'd5, 3'd0, 8'h22, 1'b0, acc);
    issue(2'd3, 3'd5, 3'd2, 8'h00, 1'b0, acc);
    issue(2'd2, 3'd6, 3'd6, 8'h00, 1'b0, acc);
    issue(2'd3, 3'd3, 3'd3, 8'h00, 1'b0, acc);

    // cmd_valid held high across LDI, MOV, NOP, LDI
    issue(2'd1, 3'd7, 3'd0, 8'h5A, 1'b1, p0);
    issue(2'd2, 3'd4, 3'd7, 8'h00, 1'b1, p1);
    issue(2'd0, 3'd0, 3'd0, 8'h00, 1'b1, p2);
    issue(2'd1, 3'd2, 3'd0, 8'h77, 1'b1, p3);
    cmd_valid = 1'b0;
    check("spacing_ldi", p1 - p0, 2);
    check("spacing_mov", p2 - p1, 3);
    check("spacing_nop", p3 - p2, 2);

    // write-protected destination (err expected only when protection is built in)
    issue(2'd1, 3'd0, 3'd0, 8'hFF, 1'b0, acc);
    issue(2'd1, 3'd4, 3'd0, 8'h44, 1'b0, acc);

    // reset in the SWA cycle of a SWAP
    cmd_op = 2'd3; cmd_src = 3'd2; cmd_dst = 3'd5; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("swa_we_before_rst", rf_we, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_outputs_now", {cmd_ready, done, err, rf_we, rf_oe, rf_iaddr, rf_oaddr, rf_idata}, 19'd0);
    @(negedge clk);
    check("rst_outputs_next", {cmd_ready, done, err, rf_we, rf_oe, rf_iaddr, rf_oaddr, rf_idata}, 19'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_abort", cmd_ready, 1'b1);
    check("abort_rf_image", pack_mem(mem), pack_mem(ref_mem));

    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      d = 3'($urandom);
      s = ($urandom_range(0, 3) == 0) ? d : 3'($urandom);
      issue(op, d, s, 8'($urandom), 1'b0, acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    w = 0;
    while ((sb_q.size() != 0 || pend) && w < 20) begin @(negedge clk); w++; end
    if (sb_q.size() != 0 || pend) begin
      tests++; fails++;
      $display("FAIL drain: got %0d items outstanding expected 0", sb_q.size());
    end
    check("we_oe_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regblock_seq.md
Name: regblock_seq

Overview:
- Command sequencer that drives the 8 x 8-bit register block's write port (we/iaddr/idata) and read port (oe/oaddr/odata).
- Accepts one register-transfer command at a time over a valid/ready handshake: NOP, load-immediate, move, or swap.
- Expands each command into a fixed sequence of read/write cycles on the register block.
- Sits between the instruction decode logic and the register block; it is the only master of the register block's ports.

Parameters:
- PROTECT_MASK, 8'h00, bit i set = register i is write-protected (used only when REGSEQ_PROTECT_EN is defined).

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE (not during rst); a command is accepted on the edge where cmd_valid & cmd_ready
- cmd_op  in  2  0=NOP, 1=LDI, 2=MOV, 3=SWAP
- cmd_dst  in  3  destination register index
- cmd_src  in  3  source register index (MOV, SWAP)
- cmd_imm  in  8  immediate value (LDI)
- done  out  1  one-cycle pulse in the final cycle of each command
- err  out  1  one-cycle pulse with done when a write was suppressed (optional feature; constant 0 otherwise)
- rf_we  out  1  register block write enable
- rf_iaddr  out  3  register block write address
- rf_idata  out  8  register block write data
- rf_oe  out  1  register block read enable
- rf_oaddr  out  3  register block read address
- rf_odata  in  8  register block read data, combinational from rf_oaddr while rf_oe=1

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE; tmp_a=tmp_b=0; latched command fields=0.
  - While rst is high: cmd_ready=0, done=0, err=0, rf_we=0, rf_oe=0, rf_iaddr=0, rf_oaddr=0, rf_idata=0.
- Outputs are decoded from registered state (Moore). In IDLE all rf_* outputs are 0.
- Accept: in IDLE with cmd_valid=1, latch op/dst/src/imm and move to the op's first state. Inputs are ignored while busy.
- NOP: IDLE -> DONE (done=1, no rf access) -> IDLE. Busy 1 cycle.
- LDI: IDLE -> LW -> IDLE. Busy 1 cycle.
  - LW: rf_we=1, rf_iaddr=dst, rf_idata=imm, done=1.
- MOV: IDLE -> MR -> MW -> IDLE. Busy 2 cycles.
  - MR: rf_oe=1, rf_oaddr=src; tmp_a<=rf_odata at end of cycle.
  - MW: rf_we=1, rf_iaddr=dst, rf_idata=tmp_a, done=1.
- SWAP: IDLE -> SRA -> SRB -> SWA -> SWB -> IDLE. Busy 4 cycles.
  - SRA: read src into tmp_a.
  - SRB: read dst into tmp_b.
  - SWA: write dst<=tmp_a.
  - SWB: write src<=tmp_b, done=1.
- rf_we and rf_oe are never both high in the same cycle.
- Back-to-back commands: cmd_ready rises in the cycle after done, giving a minimum 1-cycle gap. Command throughput = busy cycles + 1.
- src==dst:
  - MOV: still 2 cycles; rewrites the same value.
  - SWAP: still 4 cycles; register value unchanged.
- Reset mid-command aborts immediately: no further rf_we. A SWAP interrupted after SWA leaves dst updated and src unchanged; this is accepted behaviour.
- No arithmetic; all data is passed through unmodified at 8 bits.

Optional Feature:
- Macro REGSEQ_PROTECT_EN.
- Defined:
  - Any write state targeting register i with PROTECT_MASK[i]=1 drives rf_we=0; the rest of the sequence proceeds unchanged.
  - err pulses with done if any write in the command was suppressed.
  - Cycle counts are unchanged.
- Undefined: PROTECT_MASK is ignored and err is tied 0.

Test Plan:
- Reset, then LDI dst=3 imm=8'hA5 -> cmd_ready=0 for 1 cycle; LW cycle has rf_we=1, rf_iaddr=3, rf_idata=A5, done=1; cmd_ready=1 next cycle.
- Preload r1=8'h3C; MOV src=1 dst=6 -> MR cycle has rf_oe=1, rf_oaddr=1; MW cycle has rf_we=1, rf_iaddr=6, rf_idata=3C, done=1; r6=3C.
- Preload r2=8'h11, r5=8'h22; SWAP src=2 dst=5 -> 4 busy cycles, done on the 4th; final r2=22, r5=11; rf_we&rf_oe never both 1.
- cmd_valid held high with LDI, MOV, NOP queued -> accepts spaced exactly 2, 3, 2 cycles apart; input changes while busy have no effect.
- Assert rst in the SWA cycle of a SWAP -> no rf_we in the following cycle; outputs at reset values; cmd_ready=1 one cycle after rst drops.
- REGSEQ_PROTECT_EN with PROTECT_MASK=8'h01: LDI dst=0 imm=FF -> rf_we stays 0, done=1 and err=1 in the same cycle, r0 unchanged; LDI dst=4 -> normal write, err=0.
